// File: rtl/div_sched_if.sv
// rtl/div_sched_if.sv - requester and divider signal bundle for div_sched
interface div_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*DW-1:0] a_i;
  logic [NREQ*DW-1:0] b_i;
  logic [NREQ-1:0]    done_o;
  logic [DW-1:0]      quot_o;
  logic [DW-1:0]      rem_o;
  logic               dz_o;
  logic               busy_o;
  logic               err_o;
  logic               div_start_o;
  logic [DW-1:0]      div_a_o;
  logic [DW-1:0]      div_b_o;
  logic               div_ready_i;
  logic [DW-1:0]      div_quot_i;
  logic [DW-1:0]      div_rem_i;

  modport slave (
    input  req_i, a_i, b_i, div_ready_i, div_quot_i, div_rem_i,
    output done_o, quot_o, rem_o, dz_o, busy_o, err_o,
           div_start_o, div_a_o, div_b_o
  );

  modport master (
    output req_i, a_i, b_i, div_ready_i, div_quot_i, div_rem_i,
    input  done_o, quot_o, rem_o, dz_o, busy_o, err_o,
           div_start_o, div_a_o, div_b_o
  );
endinterface

// File: rtl/div_sched.sv
// rtl/div_sched.sv - round-robin scheduler sharing one divider among NREQ requesters
module div_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int TMO  = 64
) (
  input  logic      clk_i,
  input  logic      rst_i,
  div_sched_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, idx_q, win, cand;
  logic [SW-1:0]  sum;
  logic           found;
  logic [DW-1:0]  a_q, b_q, quot_q, rem_q;
  logic           dz_q, err_q, seen_busy_q;
  logic [CW-1:0]  cnt_q;
  logic           grant, div_ok, tmo_hit;
  logic [DW-1:0]  a_arr [NREQ];
  logic [DW-1:0]  b_arr [NREQ];
  logic [DW-1:0]  a_sel, b_sel;
  logic [NREQ-1:0] done_vec;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = bus.a_i[g*DW +: DW];
    assign b_arr[g] = bus.b_i[g*DW +: DW];
  end

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      cand = sum[IW-1:0];
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign a_sel   = a_arr[win];
  assign b_sel   = b_arr[win];
  assign grant   = (state_q == IDLE) && found && bus.div_ready_i;
  assign div_ok  = (state_q == WAIT) && seen_busy_q && bus.div_ready_i;
  assign tmo_hit = (state_q == WAIT) && !div_ok && (cnt_q == CW'(TMO - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = (b_sel == '0) ? DONE : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (div_ok || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      seen_busy_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            idx_q <= win;
            a_q   <= a_sel;
            b_q   <= b_sel;
            // Zero divisor never reaches the divider; answer is formed here.
            if (b_sel == '0) begin
              quot_q <= '1;
              rem_q  <= a_sel;
              dz_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          seen_busy_q <= 1'b0;
          cnt_q       <= '0;
        end
        WAIT: begin
          if (!bus.div_ready_i) seen_busy_q <= 1'b1;
          cnt_q <= cnt_q + CW'(1);
          if (div_ok) begin
            quot_q <= bus.div_quot_i;
            rem_q  <= bus.div_rem_i;
            dz_q   <= 1'b0;
          end else if (tmo_hit) begin
            err_q  <= 1'b1;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
          end
        end
        DONE: begin
          ptr_q       <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          seen_busy_q <= 1'b0;
          cnt_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done_vec = '0;
    if (state_q == DONE) done_vec[idx_q] = 1'b1;
  end

  assign bus.done_o      = done_vec;
  assign bus.quot_o      = quot_q;
  assign bus.rem_o       = rem_q;
  assign bus.dz_o        = dz_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.err_o       = err_q;
  assign bus.div_start_o = (state_q == ISSUE);
  assign bus.div_a_o     = a_q;
  assign bus.div_b_o     = b_q;

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - directed bench for div_sched with a 32-cycle divider model
module tb_div_sched;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TMO  = 64;
  localparam int LAT  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   start_cnt = 0;

  logic          dv_ready = 1'b1;
  logic          dv_hang = 1'b0;
  int            dv_cnt = 0;
  logic [DW-1:0] dv_q = '0;
  logic [DW-1:0] dv_r = '0;

  div_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  div_sched #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.div_ready_i = dv_ready;
  assign bus.div_quot_i  = dv_q;
  assign bus.div_rem_i   = dv_r;

  // Multi-cycle divider stand-in; dv_hang freezes it mid-divide.
  always @(posedge clk) begin
    if (bus.div_start_o && dv_ready) begin
      dv_ready <= 1'b0;
      dv_cnt   <= LAT;
      dv_q     <= bus.div_a_o / bus.div_b_o;
      dv_r     <= bus.div_a_o % bus.div_b_o;
    end else if (!dv_ready && !dv_hang) begin
      if (dv_cnt <= 1) dv_ready <= 1'b1;
      dv_cnt <= dv_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (|bus.done_o) done_cnt <= done_cnt + 1;
    if (bus.div_start_o) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.a_i[k*DW +: DW] = a;
    bus.b_i[k*DW +: DW] = b;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (bus.done_o === '0 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_start(input int budget);
    int cyc = 0;
    while (bus.div_start_o !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    check("start_seen", {63'd0, bus.div_start_o}, 64'd1);
  endtask

  initial begin
    int cyc;
    int d0, s0;
    logic [DW-1:0] fq [4];
    logic [DW-1:0] fr [4];
    fq[0] = 100;          fr[0] = 0;
    fq[1] = 15;           fr[1] = 2;
    fq[2] = 0;            fr[2] = 1;
    fq[3] = 32'h0FFFFFFF; fr[3] = 15;

    bus.req_i = '0;
    bus.a_i   = '0;
    bus.b_i   = '0;
    tick();
    tick();
    check("rst_done", bus.done_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_quot", bus.quot_o, 0);
    check("rst_rem", bus.rem_o, 0);
    check("rst_dz", bus.dz_o, 0);
    check("rst_start", bus.div_start_o, 0);
    check("rst_div_a", bus.div_a_o, 0);
    check("rst_div_b", bus.div_b_o, 0);
    rst = 1'b0;

    // Single divide: 100 / 7
    d0 = done_cnt; s0 = start_cnt;
    set_op(0, 100, 7);
    bus.req_i = 4'b0001;
    wait_done(200, cyc);
    check("single_done", bus.done_o, 4'b0001);
    check("single_quot", bus.quot_o, 14);
    check("single_rem", bus.rem_o, 2);
    check("single_dz", bus.dz_o, 0);
    bus.req_i = '0;
    tick();
    tick();
    check("single_pulses", done_cnt - d0, 1);
    check("single_starts", start_cnt - s0, 1);

    // Divide by zero bypasses the divider
    s0 = start_cnt;
    set_op(2, 55, 0);
    bus.req_i = 4'b0100;
    tick();
    check("dz_done", bus.done_o, 4'b0100);
    check("dz_quot", bus.quot_o, 32'hFFFFFFFF);
    check("dz_rem", bus.rem_o, 55);
    check("dz_flag", bus.dz_o, 1);
    bus.req_i = '0;
    tick();
    check("dz_pulse_end", bus.done_o, 0);
    check("dz_hold_quot", bus.quot_o, 32'hFFFFFFFF);
    check("dz_hold_rem", bus.rem_o, 55);
    check("dz_no_start", start_cnt - s0, 0);

    // Fairness: all four held from reset
    rst = 1'b1;
    set_op(0, 1000, 10);
    set_op(1, 77, 5);
    set_op(2, 1, 3);
    set_op(3, 32'hFFFFFFFF, 16);
    bus.req_i = 4'b1111;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      wait_done(200, cyc);
      check($sformatf("rr%0d_done", n), bus.done_o, 4'b0001 << (n % 4));
      check($sformatf("rr%0d_quot", n), bus.quot_o, fq[n % 4]);
      check($sformatf("rr%0d_rem", n), bus.rem_o, fr[n % 4]);
      if (n == 4) bus.req_i = '0;
      tick();
    end

    // Requester 3 queues behind requester 1
    set_op(1, 200, 9);
    bus.req_i = 4'b0010;
    wait_start(20);
    repeat (5) tick();
    set_op(3, 50, 6);
    bus.req_i = 4'b1010;
    wait_done(200, cyc);
    check("q1_done", bus.done_o, 4'b0010);
    check("q1_quot", bus.quot_o, 22);
    check("q1_rem", bus.rem_o, 2);
    bus.req_i = 4'b1000;
    tick();
    check("q_idle", bus.busy_o, 0);
    tick();
    check("q3_start", bus.div_start_o, 1);
    check("q3_div_a", bus.div_a_o, 50);
    check("q3_keep_quot", bus.quot_o, 22);
    check("q3_keep_rem", bus.rem_o, 2);
    wait_done(200, cyc);
    check("q3_done", bus.done_o, 4'b1000);
    check("q3_quot", bus.quot_o, 8);
    check("q3_rem", bus.rem_o, 2);
    bus.req_i = '0;
    tick();

    // Reset while requester 0 waits on the divider
    dv_hang = 1'b1;
    set_op(0, 90, 4);
    bus.req_i = 4'b0001;
    wait_start(20);
    repeat (5) tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", bus.busy_o, 0);
    check("mid_done", bus.done_o, 0);
    check("mid_quot", bus.quot_o, 0);
    check("mid_rem", bus.rem_o, 0);
    check("mid_div_a", bus.div_a_o, 0);
    check("mid_div_b", bus.div_b_o, 0);
    repeat (6) tick();
    check("mid_no_grant", bus.busy_o, 0);
    check("mid_no_pulse", done_cnt - d0, 0);
    dv_hang = 1'b0;
    wait_done(200, cyc);
    check("mid_regrant_done", bus.done_o, 4'b0001);
    check("mid_regrant_quot", bus.quot_o, 22);
    check("mid_regrant_rem", bus.rem_o, 2);
    bus.req_i = '0;
    tick();

    // Watchdog: divider never returns
    dv_hang = 1'b1;
    set_op(2, 10, 3);
    bus.req_i = 4'b0100;
    wait_start(20);
    wait_done(TMO + 20, cyc);
    check("wd_latency_ok", (cyc >= TMO && cyc <= TMO + 2), 1);
    check("wd_done", bus.done_o, 4'b0100);
    check("wd_quot", bus.quot_o, 0);
    check("wd_rem", bus.rem_o, 0);
    check("wd_dz", bus.dz_o, 0);
    check("wd_err", bus.err_o, 1);
    bus.req_i = '0;
    repeat (5) tick();
    check("wd_err_sticky", bus.err_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wd_err_cleared", bus.err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the divider.
REQ-002 SHALL have parameter DW, default 32: operand and result width.
REQ-003 SHALL have parameter TMO, default 64: watchdog limit, in cycles, for a divide in flight.
REQ-004 SHALL have port clk_i  in  1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 SHALL have port rst_i  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port req_i  in  NREQ: per-requester request level.
REQ-007 SHALL have port a_i  in  NREQ*DW: packed dividends; requester k uses bits [k*DW +: DW].
REQ-008 SHALL have port b_i  in  NREQ*DW: packed divisors, same packing as a_i.
REQ-009 SHALL have port done_o  out  NREQ: one-hot completion pulse.
REQ-010 SHALL have port quot_o  out  DW: quotient.
REQ-011 SHALL have port rem_o  out  DW: remainder.
REQ-012 SHALL have port dz_o  out  1: divide-by-zero flag, qualified by done_o.
REQ-013 SHALL have port busy_o  out  1: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port err_o  out  1: sticky watchdog error.
REQ-015 SHALL have port div_start_o  out  1: start pulse to the divider.
REQ-016 SHALL have ports div_a_o and div_b_o  out  DW: divider operands.
REQ-017 SHALL have port div_ready_i  in  1: divider idle, high when no divide is in progress.
REQ-018 SHALL have ports div_quot_i and div_rem_i  in  DW: divider results.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: grant SHALL occur only when |req_i and div_ready_i are both high.
- Winner is the first requester with req_i high, searching from ptr upward with wrap modulo NREQ.
- On grant, the index, a and b SHALL be latched into internal registers.
REQ-021 IDLE grant with latched b==0 SHALL bypass the divider and go directly to DONE.
- quot = all ones, rem = latched a, dz = 1.
REQ-022 IDLE grant with b!=0 SHALL go to ISSUE.
REQ-023 ISSUE: div_start_o SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
- div_a_o and div_b_o SHALL be driven from the latched registers, stable from ISSUE through DONE.
REQ-024 WAIT: a seen_busy flag SHALL set when div_ready_i is sampled low.
- When seen_busy=1 and div_ready_i=1: capture div_quot_i and div_rem_i, set dz=0, go to DONE.
REQ-025 WAIT: a cycle counter SHALL start at 0 on entry and increment every WAIT cycle.
- On reaching TMO: set err_o, set quot=0, rem=0, dz=0, go to DONE.
- err_o SHALL stay high until reset.
REQ-026 DONE: done_o[idx] SHALL pulse for exactly one cycle, with quot_o, rem_o and dz_o valid that cycle.
- ptr SHALL become (idx+1) mod NREQ; next state IDLE.
REQ-027 quot_o, rem_o and dz_o SHALL hold their last values between done pulses.
REQ-028 Requester contract:
- Hold req_i high and operands stable until done_o[k].
- Drop req_i on the edge ending the DONE cycle.
- Any req_i sampled high in IDLE is a new request.
REQ-029 Requests arriving while busy SHALL wait; none SHALL be lost or reordered within a requester.
REQ-030 Latency, b==0: done_o SHALL pulse in the cycle after the grant edge.
- b!=0: done_o SHALL pulse the cycle after WAIT samples div_ready_i high with seen_busy=1.
REQ-031 Round-robin SHALL guarantee that any request held continuously is served within NREQ grants.
REQ-032 Division SHALL be unsigned DW-bit; div_b_o SHALL never be driven with 0 while div_start_o=1.

Reset
REQ-033 rst_i high SHALL force the following at the next edge:
- FSM to IDLE, ptr=0, seen_busy=0, counter=0.
- done_o=0, div_start_o=0, busy_o=0, err_o=0.
- quot_o=0, rem_o=0, dz_o=0, div_a_o=0, div_b_o=0.
REQ-034 Reset mid-divide SHALL abandon the divide with no done_o pulse.
- No new grant SHALL issue until div_ready_i is high (REQ-020).

Verification
REQ-035 Single divide: req_i=0001, a0=100, b0=7, 32-cycle divider -> exactly one done_o=0001 pulse, quot_o=14, rem_o=2, dz_o=0, div_start_o pulsed once.
REQ-036 Divide by zero: req_i=0100, a2=55, b2=0 -> done_o=0100 pulse one cycle after grant, quot_o=FFFFFFFF, rem_o=55, dz_o=1, div_start_o never asserted.
REQ-037 Fairness: all four requesters held high from reset -> grant order 0,1,2,3,0,...; every served requester returns its own correct quotient.
REQ-038 Watchdog: divider model holds div_ready_i low forever after start -> after TMO WAIT cycles: done_o pulse, quot_o=0, rem_o=0, err_o=1 and held until reset.
REQ-039 Reset mid-divide: rst_i asserted during WAIT -> no done_o pulse; all outputs zero; new request granted only after div_ready_i returns high.
REQ-040 Queued requests: req_i[3] rises while requester 1 is in WAIT -> requester 3 is granted in the IDLE cycle after requester 1's DONE, with requester 1's results unchanged.
